// File: rtl/trig_seq_pkg.sv
// Shared types and defaults for the trigger sequencer.
// No logic here; state encoding and parameter defaults only.
package trig_seq_pkg;

  localparam int DATA_W        = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_TIMEOUT   = 4;
  localparam int DEF_MAX_RETRY = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_GAP,
    S_ERR
  } trig_seq_state_t;

endpackage

// File: rtl/trig_fifo.sv
// Byte FIFO holding host writes; full/empty are decoded from a registered count, so they move the cycle after a push/pop.
// A push while full is dropped unless a pop frees a slot in the same cycle; flush empties it but keeps a same-cycle push.
module trig_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] waddr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (flush || !full || do_pop);
  assign waddr   = flush ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[waddr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // A byte written in the flush cycle survives as the sole entry.
      rd_ptr <= '0;
      wr_ptr <= do_push ? AW'(1) : '0;
      count  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Sends queued bytes to the capture stage with a trigger, checks the confirm, retries, then flags a sticky error.
// Best case 4 cycles per byte (LOAD, ARM x2, GAP); start is ignored while busy, host writes never stall.
module trigger_sequencer
  import trig_seq_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              start,
  output logic              trig,
  output logic [DATA_W-1:0] tx_data,
  input  logic              crfm_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        sent_count
);

  localparam int WW = $clog2(TIMEOUT);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  trig_seq_state_t   state;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] hold;
  logic [WW-1:0]     wait_cnt;
  logic [RW-1:0]     retry_cnt;
  logic              retry_pend;
  logic              fifo_empty;
  logic              pop;
  logic              confirm;
  logic              timeout;
  logic              exhausted;
  logic              flush;

  assign pop       = (state == S_LOAD);
  // The first ARM cycle sees a stale capture register, so its confirm is ignored.
  assign confirm   = crfm_in && (wait_cnt != '0);
  assign timeout   = (wait_cnt == WW'(TIMEOUT - 1));
  assign exhausted = (retry_cnt == RW'(MAX_RETRY));
  assign flush     = (state == S_ARM) && !confirm && timeout && exhausted;

  trig_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (wr_en),
    .din   (wr_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hold       <= '0;
      wait_cnt   <= '0;
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
      trig       <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sent_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (!fifo_empty) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          hold       <= head;
          retry_cnt  <= '0;
          wait_cnt   <= '0;
          retry_pend <= 1'b0;
          state      <= S_ARM;
          trig       <= 1'b1;
          tx_data    <= head;
        end
        S_ARM: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (confirm) begin
            sent_count <= sent_count + 8'd1;
            state      <= S_GAP;
            trig       <= 1'b0;
            tx_data    <= '0;
          end else if (timeout) begin
            trig    <= 1'b0;
            tx_data <= '0;
            if (exhausted) begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              retry_cnt  <= retry_cnt + RW'(1);
              retry_pend <= 1'b1;
              state      <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (retry_pend) begin
            retry_pend <= 1'b0;
            wait_cnt   <= '0;
            state      <= S_ARM;
            trig       <= 1'b1;
            tx_data    <= hold;
          end else if (!fifo_empty) begin
            state <= S_LOAD;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_ERR: begin
          if (start) begin
            state <= S_IDLE;
            err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: capture-stage model plus byte scoreboard and trigger-window monitor.
module tb_trigger_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       start = 1'b0;
  logic       full;
  logic       trig;
  logic [7:0] tx_data;
  logic       crfm_in;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] sent_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int run = 0;
  int fail_left = 0;
  logic [7:0] cap_q = 8'h00;
  logic [7:0] sb_e;
  logic [7:0] exp_q[$];
  int runs_q[$];
  int rises_q[$];

  trigger_sequencer #(
    .DEPTH     (8),
    .TIMEOUT   (4),
    .MAX_RETRY (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .start      (start),
    .trig       (trig),
    .tx_data    (tx_data),
    .crfm_in    (crfm_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture stage: registers data while triggered, idles at zero, confirms on equality.
  always @(posedge clk) cap_q <= trig ? tx_data : 8'h00;
  assign crfm_in = (fail_left == 0) && (cap_q == tx_data);

  // Monitor: trigger window lengths, rise times, and confirmed bytes against the scoreboard.
  always @(negedge clk) begin
    if (trig) begin
      run = run + 1;
      if (run == 1) rises_q.push_back(cyc);
      if (crfm_in && run >= 2) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_byte got=%h required=none", tx_data);
        end else begin
          sb_e = exp_q.pop_front();
          if (tx_data !== sb_e) begin
            errors++;
            $display("FAIL sb_byte got=%h required=%h", tx_data, sb_e);
          end
        end
      end
    end else begin
      if (run != 0) begin
        runs_q.push_back(run);
        if (fail_left > 0) fail_left = fail_left - 1;
      end
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit expect_sent);
    wr_en = 1'b1;
    wr_data = b;
    if (expect_sent) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_cycles(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      if (done) dones++;
      tick();
    end
  endtask

  task automatic clear_mon();
    runs_q.delete();
    rises_q.delete();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({trig, busy, done, err, full} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b required=00000", {trig, busy, done, err, full});
    end
    checks++;
    if ({tx_data, sent_count} !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got=%h required=0000", {tx_data, sent_count});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [6:1] trig_s;
    logic [6:1] done_s;
    logic [7:0] tx2;
    logic [7:0] tx3;
    clear_mon();
    write_byte(8'hA5, 1'b1);
    pulse_start();
    for (int k = 1; k <= 6; k++) begin
      trig_s[k] = trig;
      done_s[k] = done;
      if (k == 2) tx2 = tx_data;
      if (k == 3) tx3 = tx_data;
      tick();
    end
    checks++;
    if (trig_s !== 6'b000110) begin
      errors++;
      $display("FAIL single_trig_window got=%b required=000110", trig_s);
    end
    checks++;
    if (done_s !== 6'b010000) begin
      errors++;
      $display("FAIL single_done_cycle got=%b required=010000", done_s);
    end
    checks++;
    if ({tx2, tx3} !== 16'hA5A5) begin
      errors++;
      $display("FAIL single_tx_data got=%h required=a5a5", {tx2, tx3});
    end
    checks++;
    if (sent_count !== 8'd1 || err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_count got=%0d err=%b left=%0d required=1 err=0 left=0",
               sent_count, err, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int d;
    clear_mon();
    write_byte(8'h11, 1'b1);
    write_byte(8'h22, 1'b1);
    write_byte(8'h33, 1'b1);
    pulse_start();
    run_cycles(20, d);
    checks++;
    if (d != 1) begin
      errors++;
      $display("FAIL b2b_done_pulses got=%0d required=1", d);
    end
    checks++;
    if (runs_q.size() != 3 || runs_q[0] != 2 || runs_q[1] != 2 || runs_q[2] != 2) begin
      errors++;
      $display("FAIL b2b_windows got=%p required=2,2,2", runs_q);
    end
    checks++;
    if (rises_q.size() != 3 || rises_q[1] - rises_q[0] != 4 || rises_q[2] - rises_q[1] != 4) begin
      errors++;
      $display("FAIL b2b_spacing got=%p required=4 apart", rises_q);
    end
    checks++;
    if (sent_count !== 8'd4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got=%0d left=%0d required=4 left=0", sent_count, exp_q.size());
    end
  endtask

  task automatic test_retry();
    int d;
    clear_mon();
    write_byte(8'h5C, 1'b1);
    fail_left = 1;
    pulse_start();
    run_cycles(25, d);
    checks++;
    if (runs_q.size() != 2 || runs_q[0] != 4 || runs_q[1] != 2) begin
      errors++;
      $display("FAIL retry_windows got=%p required=4,2", runs_q);
    end
    checks++;
    if (rises_q.size() != 2 || rises_q[1] - rises_q[0] != 5) begin
      errors++;
      $display("FAIL retry_spacing got=%p required=5 apart", rises_q);
    end
    checks++;
    if (sent_count !== 8'd5 || err !== 1'b0 || d != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL retry_result got=%0d err=%b done=%0d left=%0d required=5 err=0 done=1 left=0",
               sent_count, err, d, exp_q.size());
    end
  endtask

  task automatic test_error();
    int d;
    clear_mon();
    fail_left = 1000;
    write_byte(8'h77, 1'b0);
    write_byte(8'h88, 1'b0);
    pulse_start();
    run_cycles(40, d);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || trig !== 1'b0 || d != 0) begin
      errors++;
      $display("FAIL err_state got=err%b busy%b trig%b done%0d required=err1 busy0 trig0 done0",
               err, busy, trig, d);
    end
    checks++;
    if (runs_q.size() != 4 || runs_q[0] != 4 || runs_q[1] != 4 || runs_q[2] != 4 || runs_q[3] != 4) begin
      errors++;
      $display("FAIL err_attempts got=%p required=4,4,4,4", runs_q);
    end
    fail_left = 0;
    pulse_start();
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got=err%b busy%b required=err0 busy0", err, busy);
    end
    pulse_start();
    run_cycles(4, d);
    checks++;
    if (d != 1 || runs_q.size() != 4 || sent_count !== 8'd5) begin
      errors++;
      $display("FAIL err_flushed got=done%0d windows%0d sent%0d required=done1 windows4 sent5",
               d, runs_q.size(), sent_count);
    end
  endtask

  task automatic test_full();
    int d;
    clear_mon();
    for (int i = 0; i < 9; i++) begin
      write_byte(8'h80 + 8'(i), i < 8);
      if (i == 6) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL full_at_7 got=%b required=0", full);
        end
      end
      if (i == 7 || i == 8) begin
        checks++;
        if (full !== 1'b1) begin
          errors++;
          $display("FAIL full_at_%0d got=%b required=1", i + 1, full);
        end
      end
    end
    pulse_start();
    run_cycles(45, d);
    checks++;
    if (runs_q.size() != 8 || d != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_sent got=windows%0d done%0d left%0d required=windows8 done1 left0",
               runs_q.size(), d, exp_q.size());
    end
    checks++;
    if (sent_count !== 8'd13 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_count got=%0d full=%b required=13 full=0", sent_count, full);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    bit seen;
    clear_mon();
    fail_left = 1000;
    write_byte(8'h42, 1'b0);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (trig) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_mid_arm_timeout got=no trig required=trig within 10 cycles");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({trig, busy, tx_data, sent_count} !== 18'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got=trig%b busy%b tx%h sent%0d required=all 0",
               trig, busy, tx_data, sent_count);
    end
    tick();
    rst_n = 1'b1;
    fail_left = 0;
    tick();
    clear_mon();
    pulse_start();
    run_cycles(4, d);
    checks++;
    if (d != 1 || runs_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle got=done%0d windows%0d busy%b required=done1 windows0 busy0",
               d, runs_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_retry();
    test_error();
    test_full();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Transmit-side counterpart of the trigger capture stage. It buffers bytes written by a host, then, on command, presents each byte to the capture stage with a trigger pulse and checks the returned confirm. Mismatches are retried a bounded number of times before a sticky error is flagged. It sits upstream of the capture block: `trig`/`tx_data` drive its trigger/data inputs, and its confirm output returns on `crfm_in`.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 4: cycles per attempt in ARM; ≥2.
- `MAX_RETRY`, 3: extra attempts after the first failure; ≥0.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: host write strobe.
- `wr_data` in 8: byte to enqueue.
- `full` out 1: FIFO full; writes while full are dropped.
- `start` in 1: single-cycle command to send all queued bytes, or to clear ERR.
- `trig` out 1: trigger to capture stage.
- `tx_data` out 8: data to capture stage.
- `crfm_in` in 1: confirm from capture stage (combinational on its side).
- `busy` out 1: high in any state other than IDLE and ERR.
- `done` out 1: one-cycle pulse when a sequence completes.
- `err` out 1: sticky retry-exhausted flag.
- `sent_count` out 8: bytes confirmed since reset; wraps 255→0.

## Operation
- States: IDLE, LOAD, ARM, GAP, ERR. The state register is reset to IDLE.
- Outputs are Moore-decoded from registered state and holding registers, so they are glitch-free.
- Reset values: `trig`=0, `tx_data`=0, `busy`=0, `done`=0, `err`=0, `sent_count`=0, FIFO empty, `full`=0.
- **IDLE:** `trig`=0, `tx_data`=0.
  - `start` with FIFO non-empty → LOAD.
  - `start` with FIFO empty → `done` pulses the next cycle; stay in IDLE.
- **LOAD:** pop the FIFO head into the hold register; clear `retry_cnt` and `wait_cnt` → ARM.
- **ARM:** `trig`=1, `tx_data`=hold; `wait_cnt` increments each cycle.
  - `crfm_in` is ignored when `wait_cnt`=0, because the capture register has not yet updated.
  - `crfm_in`=1 with `wait_cnt`≥1 → `sent_count`+1, then GAP (success).
  - `wait_cnt`=TIMEOUT−1 with no confirm:
    - if `retry_cnt`=MAX_RETRY → ERR;
    - otherwise `retry_cnt`+1, then GAP (retry pending).
- **GAP:** one cycle with `trig`=0 and `tx_data`=0, which lets the capture stage clear.
  - Retry pending → ARM, with `wait_cnt` cleared.
  - Otherwise FIFO non-empty → LOAD.
  - Otherwise → IDLE with `done` pulse.
- **ERR:** `err`=1, `trig`=0, `tx_data`=0. The FIFO is flushed on entry.
  - `start` → IDLE and clears `err`.
  - Writes are accepted while in ERR.
- FIFO rules:
  - Writes are accepted in every state, including mid-sequence. Bytes written before GAP samples empty are sent in the same sequence.
  - A simultaneous push and pop is legal; occupancy is unchanged.
  - A push while full is dropped, except when a pop happens in the same cycle, in which case the push is accepted.
- `start` while busy is ignored.
- A byte value of 0x00 can confirm trivially, because the capture output idles at 0. This is intended and not special-cased.

## Timing
- `start` is sampled at edge 0. LOAD runs in cycle 1; `trig` is high from cycle 2.
- The capture stage registers data at the end of cycle 2. `crfm_in` is valid and sampled in cycle 3, then GAP in cycle 4.
- Best case is 4 cycles per byte: LOAD, ARM×2, GAP.
- A failed attempt costs TIMEOUT+1 cycles (ARM×TIMEOUT plus GAP).
- `done` is asserted in the cycle after the final GAP.
- `full` updates in the cycle after the write or pop that changes occupancy.
- Asserting `rst_n` mid-operation immediately drives all outputs to their reset values and discards FIFO contents.

## Structure
- Package `trig_seq_pkg`: state enum `trig_seq_state_t`, `DATA_W`=8, default parameter constants.
- Sub-module `trig_fifo`: synchronous FIFO of DEPTH×8 with `push`/`pop`/`full`/`empty`/`head` and a flush input. The top level holds the FSM, the counters and `sent_count`.

## Test plan
- Write 0xA5, pulse `start`, capture model attached → `trig` high for cycles 2–3 with `tx_data`=0xA5; `done` pulses at cycle 5; `sent_count`=1; `err`=0.
- Write 0x11, 0x22, 0x33, then `start` → three trigger windows 4 cycles apart, in order; `sent_count`=3; a single `done` pulse.
- Force `crfm_in`=0 for the first attempt on 0x5C (TIMEOUT=4) → 4 ARM cycles, GAP, then re-ARM; confirms on the retry; `err`=0.
- Force `crfm_in`=0 permanently with MAX_RETRY=3 → 4 attempts, then `err`=1; FIFO empty; `busy`=0. A following `start` clears `err`.
- Write 9 bytes with DEPTH=8 → `full`=1 after the 8th write, and the 9th byte is dropped. With the FSM idle, the sequence then sends exactly 8 bytes.
- Pull `rst_n` low while in ARM → `trig`, `tx_data` and `busy` are 0 immediately; `sent_count`=0; after release the FSM is in IDLE.
